// File: rtl/serial_result_collector_pkg.sv
// Shared constants and capture-state encoding for the serial result collector.
package serial_result_collector_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-count width able to hold 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } cap_state_e;

endpackage

// File: rtl/serial_frame_capture.sv
// Deserialises an LSB-first bit stream framed by start_c into a word, count and overflow flag.
module serial_frame_capture
  import serial_result_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_c,
  input  logic             c,
  output logic             frame_done,
  output logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  cap_state_e       state;
  logic [WIDTH-1:0] cap;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;

  // Frame end is seen on the edge that samples start_c=0; the top registers it there.
  assign frame_done = (state == COLLECT) && !start_c;
  assign word       = cap;
  assign count      = cnt;
  assign ovf        = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cap   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_c) begin
            state <= COLLECT;
            cap   <= WIDTH'(c);
            cnt   <= CNT_W'(1);
            ovf_q <= 1'b0;
          end
        end
        default: begin
          if (start_c) begin
            if (cnt < CNT_W'(WIDTH)) begin
              cap <= cap | (WIDTH'(c) << cnt);
              cnt <= cnt + CNT_W'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_result_collector.sv
// Output register and valid/ready handshake over the serial frame capture stage.
module serial_result_collector
  import serial_result_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_c,
  input  logic             c,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] bit_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             truncated,
  output logic             overrun
);

  logic             frame_done;
  logic [WIDTH-1:0] cap_word;
  logic [CNT_W-1:0] cap_count;
  logic             cap_ovf;

  serial_frame_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_capture (
    .clk        (clk),
    .reset      (reset),
    .start_c    (start_c),
    .c          (c),
    .frame_done (frame_done),
    .word       (cap_word),
    .count      (cap_count),
    .ovf        (cap_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      bit_count <= '0;
      truncated <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        // A completed frame replaces the held word only if that word is free or leaving now.
        if (!out_valid || out_ready) begin
          data_out  <= cap_word;
          bit_count <= cap_count;
          truncated <= cap_ovf;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_result_collector.sv
// Directed and randomized checks of serial_result_collector against a frame-level reference model.
module tb_serial_result_collector;
  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset, start_c, c, out_ready;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] bit_count;
  logic             out_valid, truncated, overrun;

  serial_result_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start_c(start_c), .c(c),
    .data_out(data_out), .bit_count(bit_count), .out_valid(out_valid),
    .out_ready(out_ready), .truncated(truncated), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame bits held as a list, output as a simple holding slot.
  logic       m_in_frame;
  logic       m_bits[$];
  logic       m_valid, m_trunc, m_ovr;
  logic [7:0] m_data;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_bits.delete();
    m_valid = 0; m_trunc = 0; m_ovr = 0; m_data = '0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".data"},  32'(data_out),  32'(m_data));
    chk({tag, ".count"}, 32'(bit_count), 32'(m_cnt));
    chk({tag, ".trunc"}, 32'(truncated), 32'(m_trunc));
    chk({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
  endtask

  // Advance one clock edge with the given inputs, update the model, then check.
  task automatic step(input logic s, input logic cc, input logic rdy, input string tag);
    logic       done;
    logic [7:0] w;
    int         n;
    start_c = s; c = cc; out_ready = rdy;
    @(posedge clk);
    done = m_in_frame && !s;
    w = '0;
    n = m_bits.size();
    for (int i = 0; i < n && i < WIDTH; i++) w[i] = m_bits[i];
    m_ovr = 0;
    if (done) begin
      if (!m_valid || rdy) begin
        m_data = w; m_cnt = (n < WIDTH) ? n : WIDTH; m_trunc = (n > WIDTH); m_valid = 1;
      end else m_ovr = 1;
    end else if (m_valid && rdy) m_valid = 0;
    if (s) begin
      if (!m_in_frame) m_bits.delete();
      m_bits.push_back(cc);
      m_in_frame = 1;
    end else m_in_frame = 0;
    #1;
    check_outputs(tag);
  endtask

  // Sends len bits (LSB first) then the terminating start_c=0 cycle.
  task automatic frame(input logic [15:0] bits, input int len, input logic rdy,
                       input logic rdy_end, input string tag);
    for (int i = 0; i < len; i++) step(1'b1, bits[i], rdy, tag);
    step(1'b0, 1'b0, rdy_end, tag);
  endtask

  initial begin
    reset = 1; start_c = 0; c = 0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 0;
    step(0, 0, 1, "idle");

    // Scenario 1: 1,0,0,1 -> 0x09, valid for one cycle.
    frame(16'h0009, 4, 1, 1, "s1");
    chk("s1.data09", 32'(data_out), 32'h09);
    chk("s1.cnt4", 32'(bit_count), 32'd4);
    step(0, 0, 1, "s1.drop");
    chk("s1.valid_once", 32'(out_valid), 32'd0);

    // Scenario 2: 10 ones truncated.
    frame(16'h03FF, 10, 1, 1, "s2");
    chk("s2.dataFF", 32'(data_out), 32'hFF);
    chk("s2.trunc", 32'(truncated), 32'd1);
    step(0, 0, 1, "s2.drop");

    // Scenario 3: held 0x5A, second frame 0x33 dropped with overrun.
    frame(16'h005A, 8, 0, 0, "s3a");
    frame(16'h0033, 8, 0, 0, "s3b");
    chk("s3.ovr", 32'(overrun), 32'd1);
    chk("s3.hold5A", 32'(data_out), 32'h5A);
    step(0, 0, 0, "s3.ovr_pulse");
    chk("s3.ovr_once", 32'(overrun), 32'd0);
    step(0, 0, 1, "s3.accept");
    chk("s3.cleared", 32'(out_valid), 32'd0);

    // Scenario 4: accept and new load on the same edge.
    frame(16'h0001, 8, 0, 0, "s4a");
    frame(16'h0080, 8, 0, 1, "s4b");
    chk("s4.valid", 32'(out_valid), 32'd1);
    chk("s4.data80", 32'(data_out), 32'h80);
    chk("s4.no_ovr", 32'(overrun), 32'd0);
    step(0, 0, 1, "s4.drop");

    // Scenario 5: async reset mid-frame.
    frame(16'h00FF, 8, 0, 0, "s5pre");
    step(1, 1, 0, "s5"); step(1, 0, 0, "s5"); step(1, 1, 0, "s5");
    #2 reset = 1;
    #1;
    model_reset();
    check_outputs("s5.async");
    @(posedge clk);
    #1 reset = 0;
    frame(16'h0003, 3, 1, 0, "s5b");
    chk("s5.data03", 32'(data_out), 32'h03);
    chk("s5.cnt3", 32'(bit_count), 32'd3);
    step(0, 0, 1, "s5.drop");

    // Scenario 6: back-to-back frames with one idle cycle between them.
    frame(16'h000F, 4, 1, 1, "s6a");
    chk("s6.data0F", 32'(data_out), 32'h0F);
    frame(16'h000A, 4, 1, 1, "s6b");
    chk("s6.data0A", 32'(data_out), 32'h0A);
    chk("s6.cnt4", 32'(bit_count), 32'd4);

    // Random frames, gaps and consumer backpressure.
    for (int f = 0; f < 60; f++) begin
      int len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        step(1'b1, 1'($urandom), 1'($urandom), "rnd");
      step(1'b0, 1'b0, 1'($urandom), "rnd.end");
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom), "rnd.gap");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_result_collector.md
SERIAL_RESULT_COLLECTOR -- requirements
Module: serial_result_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the result word width in bits.
REQ-002 The block SHALL have parameter CNT_W, default clog2(WIDTH+1), giving the bit-count width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start_c, input, 1 bit: frame-valid from the upstream serial stage; high while bits of c are valid.
REQ-006 The block SHALL have port c, input, 1 bit: the serial result bit, LSB first.
REQ-007 The block SHALL have port data_out, output, WIDTH bits: the assembled parallel result.
REQ-008 The block SHALL have port bit_count, output, CNT_W bits: the number of bits stored in data_out (0..WIDTH).
REQ-009 The block SHALL have port out_valid, output, 1 bit: data_out, bit_count and truncated are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-011 The block SHALL have port truncated, output, 1 bit: the frame had more than WIDTH bits.
REQ-012 The block SHALL have port overrun, output, 1 bit: a one-cycle pulse when a completed frame is dropped.

Function
REQ-013 The capture FSM SHALL have states IDLE and COLLECT.
- IDLE -> COLLECT on an edge with start_c=1; that edge samples the first bit.
REQ-014 In COLLECT, each edge with start_c=1 SHALL write c into capture-register position k, where k is the zero-based bit index of the frame.
REQ-015 Each new frame SHALL start with the capture register cleared to zero, so positions k >= frame length read 0.
REQ-016 Bits with index >= WIDTH SHALL be discarded.
- The capture count SHALL saturate at WIDTH.
- An internal overflow flag SHALL be set when such bits are discarded.
REQ-017 The first edge in COLLECT with start_c=0 SHALL end the frame and return the FSM to IDLE.
- At that edge, the captured word, count and overflow flag SHALL load into the output registers when out_valid=0 or out_ready=1.
- After that edge, out_valid SHALL read 1.
REQ-018 out_valid SHALL remain 1, with data_out, bit_count and truncated stable, until an edge where out_valid=1 and out_ready=1.
- At that edge, out_valid SHALL clear unless a frame completes on the same edge, in which case the new word loads and out_valid stays 1.
REQ-019 If a frame completes while out_valid=1 and out_ready=0:
- the new frame SHALL be dropped;
- the held output SHALL be unchanged;
- overrun SHALL pulse high for exactly one cycle.
REQ-020 Back-to-back frames separated by a single start_c=0 cycle SHALL be captured with no lost bits.
REQ-021 The latency from the frame-ending edge to out_valid=1 SHALL be one edge (registered output); the block SHALL NOT have any combinational path from its inputs to its outputs.

Reset
REQ-022 When reset=1, regardless of clk, the block SHALL force:
- FSM to IDLE;
- capture register, count and overflow flag to 0;
- data_out=0, bit_count=0, out_valid=0, truncated=0, overrun=0.
REQ-023 A frame in progress when reset asserts SHALL be abandoned.
- After reset deasserts, capture SHALL resume only at the next edge with start_c=1; if start_c is still high, that edge SHALL be treated as bit 0 of a new frame.

Structure
REQ-024 A shared package SHALL hold the default WIDTH, the CNT_W derivation and the capture-state enumeration (IDLE, COLLECT).
REQ-025 The capture FSM and register SHALL be a sub-module named serial_frame_capture.
- It SHALL output a one-cycle frame_done together with the word, count and overflow flag.
- The top level SHALL hold only the output register and the handshake logic.

Verification
REQ-026 Scenario 1: start_c=1 for 4 cycles with c=1,0,0,1, out_ready=1 -> data_out=8'h09, bit_count=4, truncated=0; out_valid high for exactly 1 cycle.
REQ-027 Scenario 2: 10-bit frame of all 1s -> data_out=8'hFF, bit_count=8, truncated=1.
REQ-028 Scenario 3: with out_ready=0, frame 8'h5A followed by frame 8'h33 -> output holds 8'h5A, overrun pulses once at the end of the second frame; setting out_ready=1 clears out_valid.
REQ-029 Scenario 4: out_valid=1 holding 8'h01, out_ready=1 on the same edge that frame 8'h80 ends -> out_valid stays 1, data_out=8'h80, no overrun.
REQ-030 Scenario 5: assert reset asynchronously after 3 bits of a frame -> all outputs 0 immediately; next full frame 1,1,0 -> data_out=8'h03, bit_count=3.
REQ-031 Scenario 6: two 4-bit frames 1,1,1,1 and 0,1,0,1 separated by one idle cycle, out_ready=1 -> outputs 8'h0F then 8'h0A, each with bit_count=4.
